// File: rtl/imem_port_arbiter_pkg.sv
// imem_port_arbiter_pkg
//   Shared types and constants for the instruction/data SRAM port arbiter.
//   - state_e   : arbiter FSM state (IDLE, IBURST)
//   - owner_e   : which requester owns an access (OWN_I refill, OWN_D LSU)
//   - rd_tag_t  : one-cycle read-return tag {valid, owner, last}
//   - ADDR_W / DATA_W / BURST_LEN / BEAT_W : bus and burst geometry
package imem_port_arbiter_pkg;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BURST_LEN = 4;
  localparam int BEAT_W    = $clog2(BURST_LEN);
  // Byte offset of a line: beat index plus the 2-bit byte-in-word offset.
  localparam int LINE_LSB  = BEAT_W + 2;

  // Bit positions in the 2-bit request/grant vectors.
  localparam int REQ_I = 0;
  localparam int REQ_D = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    IBURST = 1'b1
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   last;
  } rd_tag_t;

endpackage

// File: rtl/imem_port_arbiter_if.sv
// imem_port_arbiter_if
//   Bundles the refill-engine, LSU and SRAM signals of the port arbiter.
//   modport slave  : arbiter view (requests and mem_rdata in; grants,
//                    returned data and SRAM controls out)
//   modport master : requester/SRAM-side view, the mirror of slave
interface imem_port_arbiter_if;
  import imem_port_arbiter_pkg::*;

  // instruction cache refill engine
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic [DATA_W-1:0] i_rdata;
  logic              i_rvalid;
  logic              i_last;

  // load/store unit
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_wstrb;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rvalid;

  // SRAM macro
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [3:0]        mem_wstrb;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rdata, i_rvalid, i_last,
    input  d_req, d_we, d_wstrb, d_addr, d_wdata,
    output d_gnt, d_rdata, d_rvalid,
    output mem_addr, mem_we, mem_wstrb, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rdata, i_rvalid, i_last,
    output d_req, d_we, d_wstrb, d_addr, d_wdata,
    input  d_gnt, d_rdata, d_rvalid,
    input  mem_addr, mem_we, mem_wstrb, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/imem_port_arbiter_rr_arbiter2.sv
// rr_arbiter2
//   Two-requester round-robin picker. A lone requester is always granted;
//   when both request, the one that did not own the last access wins.
//   i_req        : request vector, bit REQ_I = refill, bit REQ_D = LSU
//   i_last_owner : owner of the most recent granted access
//   o_grant      : one-hot grant (all zero when nobody requests)
module rr_arbiter2
  import imem_port_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  owner_e     i_last_owner,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (i_last_owner == OWN_D) ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
//   Shares one synchronous-read SRAM port between the I-cache refill engine
//   (4-beat line bursts) and the LSU (single-word reads/writes). A refill
//   grant locks the port for the whole burst; contention alternates
//   round-robin; returned read words are steered by a one-cycle tag.
//   clk : clock
//   rst : synchronous, active-high reset
//   bus : imem_port_arbiter_if.slave (refill, LSU and SRAM signals)
//
//   state  | meaning
//   IDLE   | arbitrate; an I grant issues beat 0, a D grant issues one word
//   IBURST | issue refill beats 1..BURST_LEN-1, no grants
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  imem_port_arbiter_if.slave  bus
);

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  state_e                     r_state;
  logic [BEAT_W-1:0]          r_beat;
  owner_e                     r_last_owner;
  logic [ADDR_W-1:LINE_LSB]   r_line;
  rd_tag_t                    r_tag;

  logic [1:0]                 w_grant;
  logic                       w_i_gnt;
  logic                       w_d_gnt;
  rd_tag_t                    w_tag_nxt;
  logic [ADDR_W-1:0]          w_mem_addr;
  logic                       w_mem_we;
  logic [3:0]                 w_mem_wstrb;
  logic [DATA_W-1:0]          w_mem_wdata;
  logic                       w_i_rvalid;
  logic                       w_d_rvalid;
  logic                       w_unused_addr_bits;

  // Sub-line and sub-word address bits carry no information here.
  assign w_unused_addr_bits = ^{bus.i_addr[LINE_LSB-1:0], bus.d_addr[1:0]};

  rr_arbiter2 u_rr (
    .i_req        ({bus.d_req, bus.i_req}),
    .i_last_owner (r_last_owner),
    .o_grant      (w_grant)
  );

  assign w_i_gnt = (r_state == IDLE) && w_grant[REQ_I];
  assign w_d_gnt = (r_state == IDLE) && w_grant[REQ_D];

  // SRAM controls are combinational so a grant issues its address in the
  // same cycle; an idle port drives all zeros.
  always_comb begin
    w_mem_addr  = '0;
    w_mem_we    = 1'b0;
    w_mem_wstrb = 4'b0000;
    w_mem_wdata = '0;
    if (r_state == IBURST) begin
      w_mem_addr = {r_line, r_beat, 2'b00};
    end else if (w_i_gnt) begin
      w_mem_addr = {bus.i_addr[ADDR_W-1:LINE_LSB], {BEAT_W{1'b0}}, 2'b00};
    end else if (w_d_gnt) begin
      w_mem_addr  = {bus.d_addr[ADDR_W-1:2], 2'b00};
      w_mem_we    = bus.d_we;
      w_mem_wstrb = bus.d_we ? bus.d_wstrb : 4'b0000;
      w_mem_wdata = bus.d_wdata;
    end
  end

  // Tag describing the read issued this cycle; it lines up with mem_rdata
  // one cycle later.
  always_comb begin
    w_tag_nxt = '0;
    if (r_state == IBURST) begin
      w_tag_nxt.valid = 1'b1;
      w_tag_nxt.owner = OWN_I;
      w_tag_nxt.last  = (r_beat == BEAT_LAST);
    end else if (w_i_gnt) begin
      w_tag_nxt.valid = 1'b1;
      w_tag_nxt.owner = OWN_I;
    end else if (w_d_gnt && !bus.d_we) begin
      w_tag_nxt.valid = 1'b1;
      w_tag_nxt.owner = OWN_D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_beat       <= '0;
      r_last_owner <= OWN_D;
      r_line       <= '0;
      r_tag        <= '0;
    end else begin
      r_tag <= w_tag_nxt;
      case (r_state)
        IDLE: begin
          if (w_i_gnt) begin
            r_line       <= bus.i_addr[ADDR_W-1:LINE_LSB];
            r_beat       <= BEAT_W'(1);
            r_state      <= IBURST;
            r_last_owner <= OWN_I;
          end else if (w_d_gnt) begin
            r_last_owner <= OWN_D;
          end
        end
        IBURST: begin
          // The last beat wraps the counter back to zero.
          r_beat <= r_beat + BEAT_W'(1);
          if (r_beat == BEAT_LAST) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_i_rvalid = r_tag.valid && (r_tag.owner == OWN_I);
  assign w_d_rvalid = r_tag.valid && (r_tag.owner == OWN_D);

  assign bus.i_gnt     = w_i_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.i_rvalid  = w_i_rvalid;
  assign bus.i_last    = w_i_rvalid && r_tag.last;
  assign bus.d_rvalid  = w_d_rvalid;
  assign bus.i_rdata   = w_i_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rdata   = w_d_rvalid ? bus.mem_rdata : '0;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_wstrb = w_mem_wstrb;
  assign bus.mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter
//   Cycle-by-cycle directed vectors against imem_port_arbiter with a small
//   SRAM model (word at byte address a holds a for a >= 0x400, else 0).
module tb_imem_port_arbiter;
  import imem_port_arbiter_pkg::*;

  logic clk;
  logic rst;

  imem_port_arbiter_if bus ();

  imem_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];

  always @(posedge clk) begin
    if (bus.mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_wstrb[b]) mem[bus.mem_addr[13:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
    end
    bus.mem_rdata <= mem[bus.mem_addr[13:2]];
  end

  typedef struct {
    string       nm;
    logic        rst, ir;
    logic [31:0] ia;
    logic        dr, dwe;
    logic [3:0]  ds;
    logic [31:0] da, dd;
    logic        eig, edg, eiv, eil, edv;
    logic [31:0] ema;
    logic        emwe;
    logic [3:0]  ems;
    logic [31:0] emd, erd;
  } vec_t;

  int n_vec;
  int n_bad;
  vec_t tbl[$];

  function automatic vec_t mk(string nm, logic rst_i, logic ir, logic [31:0] ia,
                              logic dr, logic dwe, logic [3:0] ds, logic [31:0] da,
                              logic [31:0] dd, logic eig, logic edg, logic eiv,
                              logic eil, logic edv, logic [31:0] ema, logic emwe,
                              logic [3:0] ems, logic [31:0] emd, logic [31:0] erd);
    vec_t v;
    v.nm = nm; v.rst = rst_i; v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe;
    v.ds = ds; v.da = da; v.dd = dd; v.eig = eig; v.edg = edg; v.eiv = eiv;
    v.eil = eil; v.edv = edv; v.ema = ema; v.emwe = emwe; v.ems = ems;
    v.emd = emd; v.erd = erd;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    logic bad;
    rst         = v.rst;
    bus.i_req   = v.ir;
    bus.i_addr  = v.ia;
    bus.d_req   = v.dr;
    bus.d_we    = v.dwe;
    bus.d_wstrb = v.ds;
    bus.d_addr  = v.da;
    bus.d_wdata = v.dd;
    @(negedge clk);
    n_vec++;
    bad = (bus.i_gnt !== v.eig) || (bus.d_gnt !== v.edg) ||
          (bus.i_rvalid !== v.eiv) || (bus.i_last !== v.eil) ||
          (bus.d_rvalid !== v.edv) || (bus.mem_addr !== v.ema) ||
          (bus.mem_we !== v.emwe) || (bus.mem_wstrb !== v.ems) ||
          (bus.mem_wdata !== v.emd) ||
          (v.eiv && (bus.i_rdata !== v.erd)) ||
          (v.edv && (bus.d_rdata !== v.erd));
    if (bad) begin
      n_bad++;
      $display("FAIL vec %0d %s: got gnt_i/d=%b/%b rv_i/d=%b/%b last=%b addr=%h we=%b strb=%b wd=%h rd_i/d=%h/%h | want gnt_i/d=%b/%b rv_i/d=%b/%b last=%b addr=%h we=%b strb=%b wd=%h rd=%h",
               n_vec, v.nm, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.i_last,
               bus.mem_addr, bus.mem_we, bus.mem_wstrb, bus.mem_wdata, bus.i_rdata, bus.d_rdata,
               v.eig, v.edg, v.eiv, v.edv, v.eil, v.ema, v.emwe, v.ems, v.emd, v.erd);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 4096; k++) mem[k] = (k >= 256) ? 32'(k * 4) : 32'h0;
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_wstrb = '0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;

    //             name        rst ir ia          dr we ds      da          dd            ig dg iv il dv addr        we st    wdata         rdata
    tbl.push_back(mk("reset",   0, 0, 32'h0,     0, 0, 4'h0, 32'h0,     32'h0,        0, 0, 0, 0, 0, 32'h0,     0, 4'h0, 32'h0,        32'h0));
    // solo refill
    tbl.push_back(mk("solo_g",  0, 1, 32'h1238,  0, 0, 4'h0, 32'h0,     32'h0,        1, 0, 0, 0, 0, 32'h1230,  0, 4'h0, 32'h0,        32'h0));
    tbl.push_back(mk("solo_b1", 0, 0, 32'h0,     0, 0, 4'h0, 32'h0,     32'h0,        0, 0, 1, 0, 0, 32'h1234,  0, 4'h0, 32'h0,        32'h1230));
    tbl.push_back(mk("solo_b2", 0, 0, 32'h0,     0, 0, 4'h0, 32'h0,     32'h0,        0, 0, 1, 0, 0, 32'h1238,  0, 4'h0, 32'h0,        32'h1234));
    tbl.push_back(mk("solo_b3", 0, 0, 32'h0,     0, 0, 4'h0, 32'h0,     32'h0,        0, 0, 1, 0, 0, 32'h123C,  0, 4'h0, 32'h0,        32'h1238));
    tbl.push_back(mk("solo_r3", 0, 0, 32'h0,     0, 0, 4'h0, 32'h0,     32'h0,        0, 0, 1, 1, 0, 32'h0,     0, 4'h0, 32'h0,        32'h123C));
    tbl.push_back(mk("solo_end",0, 0, 32'h0,     0, 0, 4'h0, 32'h0,     32'h0,        0, 0, 0, 0, 0, 32'h0,     0, 4'h0, 32'h0,        32'h0));
    // contention from reset
    tbl.push_back(mk("rst2",    1, 0, 32'h0,     0, 0, 4'h0, 32'h0,     32'h0,        0, 0, 0, 0, 0, 32'h0,     0, 4'h0, 32'h0,        32'h0));
    tbl.push_back(mk("ct_g",    0, 1, 32'h2000,  1, 0, 4'h0, 32'h500,   32'h0,        1, 0, 0, 0, 0, 32'h2000,  0, 4'h0, 32'h0,        32'h0));
    tbl.push_back(mk("ct_b1",   0, 1, 32'h2000,  1, 0, 4'h0, 32'h500,   32'h0,        0, 0, 1, 0, 0, 32'h2004,  0, 4'h0, 32'h0,        32'h2000));
    tbl.push_back(mk("ct_b2",   0, 1, 32'h2000,  1, 0, 4'h0, 32'h500,   32'h0,        0, 0, 1, 0, 0, 32'h2008,  0, 4'h0, 32'h0,        32'h2004));
    tbl.push_back(mk("ct_b3",   0, 1, 32'h2000,  1, 0, 4'h0, 32'h500,   32'h0,        0, 0, 1, 0, 0, 32'h200C,  0, 4'h0, 32'h0,        32'h2008));
    tbl.push_back(mk("ct_dg",   0, 1, 32'h2000,  1, 0, 4'h0, 32'h500,   32'h0,        0, 1, 1, 1, 0, 32'h500,   0, 4'h0, 32'h0,        32'h200C));
    tbl.push_back(mk("ct_ig2",  0, 1, 32'h2000,  0, 0, 4'h0, 32'h0,     32'h0,        1, 0, 0, 0, 1, 32'h2000,  0, 4'h0, 32'h0,        32'h500));
    tbl.push_back(mk("ct2_b1",  0, 0, 32'h0,     0, 0, 4'h0, 32'h0,     32'h0,        0, 0, 1, 0, 0, 32'h2004,  0, 4'h0, 32'h0,        32'h2000));
    tbl.push_back(mk("ct2_b2",  0, 0, 32'h0,     0, 0, 4'h0, 32'h0,     32'h0,        0, 0, 1, 0, 0, 32'h2008,  0, 4'h0, 32'h0,        32'h2004));
    tbl.push_back(mk("ct2_b3",  0, 0, 32'h0,     0, 0, 4'h0, 32'h0,     32'h0,        0, 0, 1, 0, 0, 32'h200C,  0, 4'h0, 32'h0,        32'h2008));
    tbl.push_back(mk("ct2_r3",  0, 0, 32'h0,     0, 0, 4'h0, 32'h0,     32'h0,        0, 0, 1, 1, 0, 32'h0,     0, 4'h0, 32'h0,        32'h200C));
    // D write, then read-back with ignored low address bits and masked strobe
    tbl.push_back(mk("d_wr",    0, 0, 32'h0,     1, 1, 4'h3, 32'h40,    32'hDEADBEEF, 0, 1, 0, 0, 0, 32'h40,    1, 4'h3, 32'hDEADBEEF, 32'h0));
    tbl.push_back(mk("d_rd",    0, 0, 32'h0,     1, 0, 4'hF, 32'h43,    32'h12345678, 0, 1, 0, 0, 0, 32'h40,    0, 4'h0, 32'h12345678, 32'h0));
    tbl.push_back(mk("d_rd_rv", 0, 0, 32'h0,     0, 0, 4'h0, 32'h0,     32'h0,        0, 0, 0, 0, 1, 32'h0,     0, 4'h0, 32'h0,        32'h0000BEEF));
    // back-to-back D reads
    tbl.push_back(mk("bb_0",    0, 0, 32'h0,     1, 0, 4'h0, 32'h600,   32'h0,        0, 1, 0, 0, 0, 32'h600,   0, 4'h0, 32'h0,        32'h0));
    tbl.push_back(mk("bb_1",    0, 0, 32'h0,     1, 0, 4'h0, 32'h604,   32'h0,        0, 1, 0, 0, 1, 32'h604,   0, 4'h0, 32'h0,        32'h600));
    tbl.push_back(mk("bb_2",    0, 0, 32'h0,     0, 0, 4'h0, 32'h0,     32'h0,        0, 0, 0, 0, 1, 32'h0,     0, 4'h0, 32'h0,        32'h604));
    // D request raised during a burst
    tbl.push_back(mk("db_g",    0, 1, 32'h3004,  0, 0, 4'h0, 32'h0,     32'h0,        1, 0, 0, 0, 0, 32'h3000,  0, 4'h0, 32'h0,        32'h0));
    tbl.push_back(mk("db_b1",   0, 0, 32'h0,     1, 0, 4'h0, 32'h700,   32'h0,        0, 0, 1, 0, 0, 32'h3004,  0, 4'h0, 32'h0,        32'h3000));
    tbl.push_back(mk("db_b2",   0, 0, 32'h0,     1, 0, 4'h0, 32'h700,   32'h0,        0, 0, 1, 0, 0, 32'h3008,  0, 4'h0, 32'h0,        32'h3004));
    tbl.push_back(mk("db_b3",   0, 0, 32'h0,     1, 0, 4'h0, 32'h700,   32'h0,        0, 0, 1, 0, 0, 32'h300C,  0, 4'h0, 32'h0,        32'h3008));
    tbl.push_back(mk("db_dg",   0, 0, 32'h0,     1, 0, 4'h0, 32'h700,   32'h0,        0, 1, 1, 1, 0, 32'h700,   0, 4'h0, 32'h0,        32'h300C));
    tbl.push_back(mk("db_drv",  0, 0, 32'h0,     0, 0, 4'h0, 32'h0,     32'h0,        0, 0, 0, 0, 1, 32'h0,     0, 4'h0, 32'h0,        32'h700));

    foreach (tbl[i]) apply(tbl[i]);

    // Reset in the middle of a burst: G, G+1, rst at G+2, then idle checks.
    apply(mk("ra_g",   0, 1, 32'h1000, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 32'h1000, 0, 4'h0, 32'h0, 32'h0));
    apply(mk("ra_b1",  0, 0, 32'h0,    0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 1, 0, 0, 32'h1004, 0, 4'h0, 32'h0, 32'h1000));
    rst = 1'b1;
    @(posedge clk);
    #1;
    apply(mk("ra_g3",  0, 0, 32'h0,    0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0,    0, 4'h0, 32'h0, 32'h0));
    // Both request at G+4: reset left last_owner = D, so I wins.
    apply(mk("ra_g4",  0, 1, 32'h1000, 1, 0, 4'h0, 32'h800, 32'h0, 1, 0, 0, 0, 0, 32'h1000, 0, 4'h0, 32'h0, 32'h0));
    apply(mk("ra2_b1", 0, 0, 32'h0,    0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 1, 0, 0, 32'h1004, 0, 4'h0, 32'h0, 32'h1000));
    apply(mk("ra2_b2", 0, 0, 32'h0,    0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 1, 0, 0, 32'h1008, 0, 4'h0, 32'h0, 32'h1004));
    apply(mk("ra2_b3", 0, 0, 32'h0,    0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 1, 0, 0, 32'h100C, 0, 4'h0, 32'h0, 32'h1008));
    apply(mk("ra2_r3", 0, 0, 32'h0,    0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 1, 1, 0, 32'h0,    0, 4'h0, 32'h0, 32'h100C));
    apply(mk("ra_dg",  0, 0, 32'h0,    1, 0, 4'h0, 32'h800, 32'h0, 0, 1, 0, 0, 0, 32'h800, 0, 4'h0, 32'h0, 32'h0));
    apply(mk("ra_drv", 0, 0, 32'h0,    0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 32'h0,    0, 4'h0, 32'h0, 32'h800));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Shares the single synchronous-read instruction/data SRAM port between the instruction cache refill engine (4-beat line bursts) and the load/store unit (single-word reads and writes). It sits between the cache/LSU and the SRAM macro. It locks the port for a whole refill burst, alternates ownership round-robin when both sides request, and routes each returned read word to its owner.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, SRAM word width
- BURST_LEN, 4, words per cache line (16 B); beat counter is log2(BURST_LEN) bits
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_req  in  1  refill request; held with i_addr until i_gnt
- i_addr  in  ADDR_W  line address; bits [3:0] ignored
- i_gnt  out  1  one-cycle grant pulse for the refill burst
- i_rdata  out  DATA_W  returned refill word
- i_rvalid  out  1  i_rdata valid this cycle
- i_last  out  1  with i_rvalid, marks beat 3
- d_req  in  1  LSU request; held with d_* until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_wstrb  in  4  byte enables for writes
- d_addr  in  ADDR_W  word address; bits [1:0] ignored
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  one-cycle grant; a write completes on d_gnt
- d_rdata  out  DATA_W  read data
- d_rvalid  out  1  d_rdata valid; reads only
- mem_addr  out  ADDR_W  SRAM address, word aligned
- mem_we  out  1  SRAM write enable
- mem_wstrb  out  4  SRAM byte enables
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid one cycle after its address

## Operation
- FSM states: IDLE and IBURST. A 2-bit beat counter and a last_owner bit (I/D) are kept.
- In IDLE, arbitration is combinational:
  - One requester: grant it.
  - Both requesters: grant the one that is not last_owner.
  - last_owner is set to D on reset, so the first contest goes to I.
- I grant, cycle G:
  - i_gnt=1; latch i_addr[31:4].
  - mem_addr = {addr[31:4], beat, 2'b00} with beat 0; beat <= 1; go to IBURST; last_owner <= I.
- IBURST:
  - Issue beats 1..3 on consecutive cycles.
  - After the beat-3 address cycle, go to IDLE; beat wraps to 0.
  - No grants are issued while in IBURST.
- D grant, cycle G:
  - d_gnt=1; drive mem_addr = {d_addr[31:2], 2'b00}, mem_we = d_we, mem_wstrb = d_we ? d_wstrb : 0, mem_wdata = d_wdata.
  - last_owner <= D; FSM stays in IDLE.
- Read return: a registered tag (owner, is_read, is_last) follows each issued read by one cycle.
  - Next cycle, mem_rdata is steered to i_rdata (i_rvalid, plus i_last when is_last) or to d_rdata (d_rvalid).
  - i_rdata/d_rdata are a direct mux of mem_rdata; only the tag is registered.
- Idle outputs: mem_addr=0, mem_we=0, mem_wstrb=0, mem_wdata=0.
- A requester may drop its request before it is granted; nothing is issued for it.

## Timing
- Reset values: i_gnt, d_gnt, i_rvalid, i_last, d_rvalid, mem_we, mem_wstrb = 0; mem_addr, mem_wdata = 0; state = IDLE; beat = 0; last_owner = D; read tag cleared.
- Refill: grant at G, addresses at G..G+3, i_rvalid at G+1..G+4, i_last at G+4. The next grant may occur at G+4, so the return of beat 3 overlaps the next access's address cycle.
- D read: grant at G, d_rvalid at G+1. Back-to-back D reads are allowed every cycle while i_req=0.
- Fairness: with both requesting continuously, the pattern is I burst (4 cycles), D (1 cycle), I, D, ... Worst-case D wait is 4 cycles; worst-case I wait is 1 cycle.
- A request arriving during IBURST waits; it is evaluated in the first IDLE cycle.
- rst during IBURST aborts the burst. No i_rvalid appears in the cycle after rst, because the tag is cleared.
- Writes never generate rvalid.

## Structure
- Shared package: state enum {IDLE, IBURST}; owner enum {OWN_I, OWN_D}; BURST_LEN and beat width constants; read-tag struct {valid, owner, last}.
- Sub-module rr_arbiter2: 2-request round-robin picker (inputs req[1:0], last_owner; output grant one-hot).

## Test plan
- Solo refill: i_addr=0x0000_1238, SRAM word n = address → mem_addr 0x1230, 0x1234, 0x1238, 0x123C at G..G+3; i_rvalid at G+1..G+4 with the same data; i_last only at G+4.
- Contention from reset: i_req and d_req raised together → I granted first; d_gnt at G+4 with d_addr issued; d_rvalid at G+5; then I granted at G+5.
- D write: d_we=1, d_wstrb=4'b0011, d_addr=0x40, d_wdata=0xDEADBEEF → single mem_we cycle with strobe 0011 at 0x40; no d_rvalid; a following read of 0x40 returns 0x0000BEEF over 0 init.
- D request during IBURST (raised at G+1) → no grant until G+4; d_gnt at G+4; i_rvalid beat 3 and the D address cycle coincide at G+4 with correct routing.
- rst asserted at G+2 of a burst → at G+3 state is IDLE, all outputs are at reset values, and no i_rvalid appears at G+3 or G+4.
